fir_sym_mac: RTL and testbench

FIR_SYM_MAC -- requirements
Module: fir_sym_mac

---
 rtl/fir_sym_mac_pkg.sv | 24 ++
 rtl/fir_sym_mac_if.sv | 23 ++
 rtl/fir_coef_bank.sv | 34 +++
 rtl/fir_sym_mac.sv | 131 +++++++++++++
 tb/tb_fir_sym_mac.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sym_mac_pkg.sv
// Shared constants, FSM state type and default coefficient table for the
// symmetric 40-tap FIR multiply-accumulate engine.
package fir_pkg;

  localparam int WIDTH     = 3;
  localparam int DEPTH     = 40;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 25;
  localparam int NUM_PAIRS = 20;
  localparam int K_W       = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_e;

  localparam logic signed [COEF_W-1:0] COEF_DEFAULT [NUM_PAIRS] = '{
    16'sd12,    -16'sd310,  -16'sd415,  16'sd7,     16'sd882,
    16'sd1703,  16'sd1400,  -16'sd604,  -16'sd3500, -16'sd5207,
    -16'sd3001, 16'sd4502,  16'sd15003, 16'sd26000, 16'sd32000,
    16'sd31000, 16'sd29000, -16'sd28000, 16'sd20000, 16'sd32767
  };

endpackage

// File: rtl/fir_sym_mac_if.sv
// Sample-strobe / tap-vector / result bundle between a sample source and the
// FIR MAC engine.
interface fir_sym_mac_if;
  import fir_pkg::*;

  logic                        iEnSample600k;
  logic [DEPTH*WIDTH-1:0]      iTaps;
  logic signed [ACC_W-1:0]     oFirOut;
  logic                        oValid;
  logic                        oOverrun;
  logic                        oBusy;

  modport master (
    output iEnSample600k, iTaps,
    input  oFirOut, oValid, oOverrun, oBusy
  );

  modport slave (
    input  iEnSample600k, iTaps,
    output oFirOut, oValid, oOverrun, oBusy
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient store read by pair index: constant ROM by default, or a
// reset-initialised writable register file when FIR_COEF_WR_EN is defined.
module fir_coef_bank
  import fir_pkg::*;
(
`ifdef FIR_COEF_WR_EN
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [K_W-1:0]           wr_addr_i,
  input  logic signed [COEF_W-1:0] wr_data_i,
`endif
  input  logic [K_W-1:0]           rd_idx_i,
  output logic signed [COEF_W-1:0] coef_o
);

`ifdef FIR_COEF_WR_EN
  logic signed [COEF_W-1:0] coef_q [NUM_PAIRS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coef_q <= COEF_DEFAULT;
    end else if (wr_en_i && (wr_addr_i < K_W'(NUM_PAIRS))) begin
      coef_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read: a write on the same edge is seen only from the next cycle.
  assign coef_o = coef_q[rd_idx_i];
`else
  assign coef_o = COEF_DEFAULT[rd_idx_i];
`endif

endmodule

// File: rtl/fir_sym_mac.sv
// Symmetric-folded FIR engine: one coefficient pair per clock, 20 clocks per
// sample. Define FIR_COEF_WR_EN to add a runtime coefficient write port.
module fir_sym_mac #(
  parameter int WIDTH  = fir_pkg::WIDTH,
  parameter int DEPTH  = fir_pkg::DEPTH,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ACC_W  = fir_pkg::ACC_W
) (
  input  logic              iClk12M,
  input  logic              iRst,
`ifdef FIR_COEF_WR_EN
  input  logic              iCoefWrEn,
  input  logic [4:0]        iCoefAddr,
  input  logic signed [COEF_W-1:0] iCoefData,
`endif
  fir_sym_mac_if.slave      bus
);
  import fir_pkg::*;

  localparam int PAIRS  = DEPTH / 2;
  localparam int SUM_W  = WIDTH + 1;
  localparam int PROD_W = SUM_W + COEF_W;

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DEPTH*WIDTH-1:0]   snap_q, snap_d;
  logic signed [ACC_W-1:0]  out_q, out_d;
  logic                     vld_q, vld_d;
  logic                     ovr_q, ovr_d;

  logic signed [COEF_W-1:0] coef;
  logic signed [WIDTH-1:0]  tap_lo, tap_hi;
  logic signed [ACC_W-1:0]  term;
  logic                     strobe, last_pair;

  function automatic logic signed [ACC_W-1:0] pair_term(
    input logic signed [WIDTH-1:0]  a,
    input logic signed [WIDTH-1:0]  b,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [SUM_W-1:0]  s;
    logic signed [PROD_W-1:0] p;
    s = SUM_W'(a) + SUM_W'(b);
    p = PROD_W'(s) * PROD_W'(c);
    return ACC_W'(p);
  endfunction

  fir_coef_bank u_coef (
`ifdef FIR_COEF_WR_EN
    .clk_i     (iClk12M),
    .rst_i     (iRst),
    .wr_en_i   (iCoefWrEn),
    .wr_addr_i (iCoefAddr),
    .wr_data_i (iCoefData),
`endif
    .rd_idx_i  (k_q),
    .coef_o    (coef)
  );

  assign strobe    = bus.iEnSample600k;
  assign last_pair = (k_q == K_W'(PAIRS - 1));
  // Pair k folds tap k+1 with its mirror tap DEPTH-k.
  assign tap_lo    = snap_q[int'(k_q)*WIDTH +: WIDTH];
  assign tap_hi    = snap_q[(DEPTH-1-int'(k_q))*WIDTH +: WIDTH];
  assign term      = pair_term(tap_lo, tap_hi, coef);

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strobe) state_d = ST_MAC;
      ST_MAC:  if (last_pair && !strobe) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    snap_d = snap_q;
    acc_d  = acc_q;
    k_d    = k_q;
    out_d  = out_q;
    vld_d  = 1'b0;
    ovr_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (strobe) begin
        snap_d = bus.iTaps;
        acc_d  = '0;
        k_d    = '0;
      end
    end else if (last_pair) begin
      out_d = acc_q + term;
      vld_d = 1'b1;
      // A strobe landing on the final pair starts the next sample with no bubble.
      if (strobe) begin
        snap_d = bus.iTaps;
        acc_d  = '0;
        k_d    = '0;
      end
    end else begin
      acc_d = acc_q + term;
      k_d   = k_q + K_W'(1);
      ovr_d = strobe;
    end
  end

  assign bus.oBusy    = (state_q == ST_MAC);
  assign bus.oFirOut  = out_q;
  assign bus.oValid   = vld_q;
  assign bus.oOverrun = ovr_q;

endmodule

// File: tb/tb_fir_sym_mac.sv
// Randomised and directed bench for fir_sym_mac against a direct-form
// (unfolded) convolution model of the 40-tap symmetric filter.
module tb_fir_sym_mac;
  import fir_pkg::*;

  localparam int TW = DEPTH * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_sym_mac_if bus ();

`ifdef FIR_COEF_WR_EN
  logic              coef_wr_en = 1'b0;
  logic [4:0]        coef_addr  = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
`endif

  fir_sym_mac dut (
    .iClk12M   (clk),
    .iRst      (rst),
`ifdef FIR_COEF_WR_EN
    .iCoefWrEn (coef_wr_en),
    .iCoefAddr (coef_addr),
    .iCoefData (coef_data),
`endif
    .bus       (bus)
  );

  int     n_chk = 0;
  int     n_pass = 0;
  int     n_ovr = 0;
  int     n_valid = 0;
  int     n_busy_drop = 0;
  bit     busy_watch = 1'b0;
  longint exp_q[$];
  longint vt_q[$];
  longint fire_t;
  int     coef_m [NUM_PAIRS];
  longint sumc;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Direct-form convolution: tap n uses coefficient min(n-1, DEPTH-n).
  function automatic longint model(input logic [TW-1:0] taps);
    longint s;
    logic signed [WIDTH-1:0] t;
    int j;
    s = 0;
    for (int n = 1; n <= DEPTH; n++) begin
      t = taps[n*WIDTH-1 -: WIDTH];
      j = (n <= DEPTH/2) ? n - 1 : DEPTH - n;
      s += longint'(t) * longint'(coef_m[j]);
    end
    return s;
  endfunction

  function automatic logic [TW-1:0] rand_taps();
    logic [TW-1:0] r;
    for (int n = 0; n < DEPTH; n++) r[n*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 7));
    return r;
  endfunction

  function automatic logic [TW-1:0] fill_taps(input logic [WIDTH-1:0] v);
    logic [TW-1:0] r;
    for (int n = 0; n < DEPTH; n++) r[n*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  task automatic fire(input logic [TW-1:0] taps, input bit accept);
    bus.iTaps = taps;
    bus.iEnSample600k = 1'b1;
    if (accept) exp_q.push_back(model(taps));
    fire_t = $time;
    @(negedge clk);
    bus.iEnSample600k = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, longint'(exp_q.size()), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_PAIRS; i++) coef_m[i] = int'(COEF_DEFAULT[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.oOverrun) n_ovr++;
      if (busy_watch && exp_q.size() != 0 && !bus.oValid && !bus.oBusy) n_busy_drop++;
      if (bus.oValid) begin
        vt_q.push_back($time);
        n_valid++;
        check("valid_pending", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("fir_out", bus.oFirOut, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] t;
    int v0;
    bus.iEnSample600k = 1'b0;
    bus.iTaps = '0;
    for (int i = 0; i < NUM_PAIRS; i++) coef_m[i] = int'(COEF_DEFAULT[i]);
    sumc = 0;
    for (int i = 0; i < NUM_PAIRS; i++) sumc += longint'(COEF_DEFAULT[i]);

    // Reset with a coincident strobe
    @(negedge clk);
    rst = 1'b1;
    bus.iEnSample600k = 1'b1;
    bus.iTaps = fill_taps(3'b011);
    repeat (3) @(negedge clk);
    check("rst_out", bus.oFirOut, 0);
    check("rst_valid", bus.oValid, 0);
    check("rst_ovr", bus.oOverrun, 0);
    check("rst_busy", bus.oBusy, 0);
    rst = 1'b0;
    bus.iEnSample600k = 1'b0;
    @(negedge clk);
    check("rst_strobe_ignored", bus.oBusy, 0);

    // Impulses at both ends of the delay line
    t = '0; t[WIDTH-1:0] = WIDTH'(1);
    fire(t, 1'b1);
    wait_drain("imp1");
    check("imp1_latency", (vt_q[vt_q.size()-1] - fire_t) / 10 - 1, 20);
    check("imp1_value", bus.oFirOut, longint'(COEF_DEFAULT[0]));
    check("imp1_pulse", bus.oValid, 0);
    t = '0; t[TW-1 -: WIDTH] = WIDTH'(1);
    fire(t, 1'b1);
    wait_drain("imp40");
    check("imp40_value", bus.oFirOut, longint'(COEF_DEFAULT[0]));

    // Extreme constant inputs
    fire(fill_taps(3'b011), 1'b1);
    wait_drain("all_p3");
    check("all_p3_value", bus.oFirOut, 6 * sumc);
    fire(fill_taps(3'b100), 1'b1);
    wait_drain("all_m4");
    check("all_m4_value", bus.oFirOut, -8 * sumc);

    // Back-to-back random samples at the nominal 20-clock rate
    vt_q.delete();
    v0 = n_valid;
    for (int s = 0; s < 10; s++) begin
      fire(rand_taps(), 1'b1);
      busy_watch = 1'b1;
      if (s < 9) repeat (19) @(negedge clk);
    end
    wait_drain("b2b");
    busy_watch = 1'b0;
    check("b2b_count", n_valid - v0, 10);
    check("b2b_busy_drops", n_busy_drop, 0);
    for (int i = 1; i < vt_q.size(); i++) check("b2b_spacing", (vt_q[i] - vt_q[i-1]) / 10, 20);

    // Overrun strobe at k=5 with the tap bus changed after the snapshot
    fire(rand_taps(), 1'b1);
    repeat (4) @(negedge clk);
    bus.iTaps = rand_taps();
    bus.iEnSample600k = 1'b1;
    @(negedge clk);
    check("ovr_pulse", bus.oOverrun, 1);
    bus.iEnSample600k = 1'b0;
    @(negedge clk);
    check("ovr_single", bus.oOverrun, 0);
    wait_drain("ovr");
    repeat (25) @(negedge clk);
    check("ovr_idle", bus.oBusy, 0);

    // Reset at k=10 abandons the sample; a fresh strobe 3 clocks later
    fire(rand_taps(), 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", bus.oFirOut, 0);
    check("midrst_valid", bus.oValid, 0);
    check("midrst_ovr", bus.oOverrun, 0);
    check("midrst_busy", bus.oBusy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fire(rand_taps(), 1'b1);
    wait_drain("post_rst");
    repeat (25) @(negedge clk);
    check("post_rst_pending", longint'(exp_q.size()), 0);

`ifdef FIR_COEF_WR_EN
    coef_wr_en = 1'b1; coef_addr = 5'd0; coef_data = 16'sd100;
    @(negedge clk);
    coef_wr_en = 1'b0;
    coef_m[0] = 100;
    t = '0; t[WIDTH-1:0] = WIDTH'(1);
    fire(t, 1'b1);
    wait_drain("wr0");
    check("wr0_value", bus.oFirOut, 100);
    coef_wr_en = 1'b1; coef_addr = 5'd25; coef_data = 16'sd777;
    @(negedge clk);
    coef_wr_en = 1'b0;
    fire(fill_taps(3'b001), 1'b1);
    wait_drain("wr25");
    check("wr25_value", bus.oFirOut, 2 * (sumc - longint'(COEF_DEFAULT[0]) + 100));
    do_reset();
    fire(t, 1'b1);
    wait_drain("wr_rst");
    check("wr_rst_value", bus.oFirOut, longint'(COEF_DEFAULT[0]));
`endif

    check("ovr_count", n_ovr, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
